// File: rtl/xmem_pkg.sv
// xmem_pkg: shared constants, state encoding and strobe decode for the
// external latched-address memory sequencer.
//   - BUS_W            : width of the shared bidirectional bus
//   - READ_WAIT_DEF    : default MOE hold before read data is sampled
//   - WRITE_PULSE_DEF  : default MWE high time
//   - PORT_CPU/HOST    : requester indices
//   - state_t / ST_*   : sequencer state encoding
//   - strobe_t         : bundle of bus/strobe outputs, decoded per state
package xmem_pkg;

  localparam int BUS_W           = 8;
  localparam int READ_WAIT_DEF   = 2;
  localparam int WRITE_PULSE_DEF = 1;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_ADDR     = 4'd1;
  localparam state_t ST_HOLD     = 4'd2;
  localparam state_t ST_RD_TURN  = 4'd3;
  localparam state_t ST_RD_WAIT  = 4'd4;
  localparam state_t ST_WR_DATA  = 4'd5;
  localparam state_t ST_WR_PULSE = 4'd6;
  localparam state_t ST_WR_HOLD  = 4'd7;
  localparam state_t ST_DONE     = 4'd8;

  typedef struct packed {
    logic             le;
    logic             moe;
    logic             mwe;
    logic             bus_oe;
    logic [BUS_W-1:0] bus_out;
  } strobe_t;

  // Idle/reset bus condition: block owns the bus, drives zero, no strobes.
  localparam strobe_t STROBE_RST = {1'b0, 1'b0, 1'b0, 1'b1, {BUS_W{1'b0}}};

  // Strobe pattern for a given state; the caller registers the result so
  // every strobe leaves a flop.
  function automatic strobe_t decode_strobes(input state_t           st,
                                             input logic [BUS_W-1:0] addr,
                                             input logic [BUS_W-1:0] wdata);
    strobe_t s;
    s = STROBE_RST;
    case (st)
      ST_IDLE:     s = STROBE_RST;
      ST_ADDR:     begin s.le = 1'b1; s.bus_out = addr; end
      ST_HOLD:     s.bus_out = addr;
      ST_RD_TURN:  s.bus_oe = 1'b0;
      ST_RD_WAIT:  begin s.bus_oe = 1'b0; s.moe = 1'b1; end
      ST_WR_DATA:  s.bus_out = wdata;
      ST_WR_PULSE: begin s.bus_out = wdata; s.mwe = 1'b1; end
      ST_WR_HOLD:  s.bus_out = wdata;
      ST_DONE:     s = STROBE_RST;
      default:     s = STROBE_RST;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/xmem_bus_arbiter_rr_arb2.sv
// rr_arb2: two-request round-robin arbiter.
//   clk, reset  : clock, synchronous active-high reset (pointer -> PORT_CPU)
//   en          : arbitration enable (sequencer idle)
//   req[1:0]    : request levels
//   gnt_valid   : a grant is issued this cycle
//   gnt_idx     : granted port; the pointer port wins a tie
// On every grant the pointer moves to the port that did not win.
module rr_arb2
  import xmem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic ptr_r;

  // Grant decision: pointer port first, otherwise the other port.
  always_comb begin
    gnt_valid = en & (|req);
    if (req[ptr_r]) begin
      gnt_idx = ptr_r;
    end else begin
      gnt_idx = ~ptr_r;
    end
  end

  // Pointer update on grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= PORT_CPU;
    end else if (gnt_valid) begin
      ptr_r <= ~gnt_idx;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/xmem_bus_arbiter.sv
// xmem_bus_arbiter: two-port sequencer for the external latched-address
// memory on the shared 8-bit bus. One full read or write per grant.
//   clk, reset               : clock, synchronous active-high reset
//   req/we/addr/wdata[0|1]   : port 0 = core, port 1 = host loader
//   done[0|1]                : one-cycle completion pulse
//   rdata[0|1]               : read data, valid with done, held until next read
//   bus_out/bus_in/bus_oe    : shared bus drive, sample, and drive enable
//   le/moe/mwe               : address latch, output enable, write enable
module xmem_bus_arbiter
  import xmem_pkg::*;
#(
  parameter int READ_WAIT   = READ_WAIT_DEF,
  parameter int WRITE_PULSE = WRITE_PULSE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [BUS_W-1:0] addr0,
  input  logic [BUS_W-1:0] addr1,
  input  logic [BUS_W-1:0] wdata0,
  input  logic [BUS_W-1:0] wdata1,
  output logic             done0,
  output logic             done1,
  output logic [BUS_W-1:0] rdata0,
  output logic [BUS_W-1:0] rdata1,
  output logic [BUS_W-1:0] bus_out,
  input  logic [BUS_W-1:0] bus_in,
  output logic             bus_oe,
  output logic             le,
  output logic             moe,
  output logic             mwe
);

  localparam logic [2:0] READ_LAST  = 3'(READ_WAIT);
  localparam logic [2:0] PULSE_LAST = 3'(WRITE_PULSE);

  state_t           state_r, state_nxt_s;
  logic [2:0]       cnt_r, cnt_nxt_s;
  logic             port_r, port_nxt_s;
  logic             we_r, we_nxt_s;
  logic [BUS_W-1:0] addr_r, addr_nxt_s;
  logic [BUS_W-1:0] wdata_r, wdata_nxt_s;
  strobe_t          strobe_r;
  logic             gnt_valid_s;
  logic             gnt_idx_s;

  rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .en        (state_r == ST_IDLE),
    .req       ({req1, req0}),
    .gnt_valid (gnt_valid_s),
    .gnt_idx   (gnt_idx_s)
  );

  // Next state, wait/pulse counter and the request latched at grant.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    port_nxt_s  = port_r;
    we_nxt_s    = we_r;
    addr_nxt_s  = addr_r;
    wdata_nxt_s = wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (gnt_valid_s) begin
          state_nxt_s = ST_ADDR;
          port_nxt_s  = gnt_idx_s;
          we_nxt_s    = (gnt_idx_s == PORT_HOST) ? we1 : we0;
          addr_nxt_s  = (gnt_idx_s == PORT_HOST) ? addr1 : addr0;
          wdata_nxt_s = (gnt_idx_s == PORT_HOST) ? wdata1 : wdata0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADDR: state_nxt_s = ST_HOLD;
      ST_HOLD: begin
        if (we_r) begin
          state_nxt_s = ST_WR_DATA;
        end else begin
          state_nxt_s = ST_RD_TURN;
        end
      end
      ST_RD_TURN: begin
        state_nxt_s = ST_RD_WAIT;
        cnt_nxt_s   = 3'd1;
      end
      ST_RD_WAIT: begin
        // Counter stops at the parameter value, never wraps.
        if (cnt_r >= READ_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          cnt_nxt_s = cnt_r + 3'd1;
        end
      end
      ST_WR_DATA: begin
        state_nxt_s = ST_WR_PULSE;
        cnt_nxt_s   = 3'd1;
      end
      ST_WR_PULSE: begin
        if (cnt_r >= PULSE_LAST) begin
          state_nxt_s = ST_WR_HOLD;
        end else begin
          cnt_nxt_s = cnt_r + 3'd1;
        end
      end
      ST_WR_HOLD: state_nxt_s = ST_DONE;
      ST_DONE:    state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // Sequencer state plus strobes/done registered from the next state, so
  // outputs line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 3'd0;
      port_r   <= PORT_CPU;
      we_r     <= 1'b0;
      addr_r   <= {BUS_W{1'b0}};
      wdata_r  <= {BUS_W{1'b0}};
      strobe_r <= STROBE_RST;
      done0    <= 1'b0;
      done1    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      port_r   <= port_nxt_s;
      we_r     <= we_nxt_s;
      addr_r   <= addr_nxt_s;
      wdata_r  <= wdata_nxt_s;
      strobe_r <= decode_strobes(state_nxt_s, addr_nxt_s, wdata_nxt_s);
      done0    <= (state_nxt_s == ST_DONE) && (port_nxt_s == PORT_CPU);
      done1    <= (state_nxt_s == ST_DONE) && (port_nxt_s == PORT_HOST);
    end
  end

  // Read data capture at the edge that ends the last RD_WAIT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata0 <= {BUS_W{1'b0}};
      rdata1 <= {BUS_W{1'b0}};
    end else if ((state_r == ST_RD_WAIT) && (cnt_r >= READ_LAST)) begin
      if (port_r == PORT_HOST) begin
        rdata1 <= bus_in;
      end else begin
        rdata0 <= bus_in;
      end
    end else begin
      rdata0 <= rdata0;
      rdata1 <= rdata1;
    end
  end

  assign le      = strobe_r.le;
  assign moe     = strobe_r.moe;
  assign mwe     = strobe_r.mwe;
  assign bus_oe  = strobe_r.bus_oe;
  assign bus_out = strobe_r.bus_out;

endmodule

// File: tb/tb_xmem_bus_arbiter.sv
// tb_xmem_bus_arbiter: scoreboard bench for xmem_bus_arbiter with an
// external latch + memory model on the shared bus. Expected transactions
// are queued in service order; a negedge monitor pops one at each address
// latch strobe and checks every strobe cycle by cycle against the timing.
module tb_xmem_bus_arbiter;

  localparam int RW = 2;
  localparam int WP = 1;

  typedef struct {
    bit       port;
    bit       we;
    bit [7:0] addr;
    bit [7:0] wdata;
    bit [7:0] rexp;
  } txn_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = 8'h00, addr1 = 8'h00, wdata0 = 8'h00, wdata1 = 8'h00;
  logic       done0, done1, bus_oe, le, moe, mwe;
  logic [7:0] rdata0, rdata1, bus_out, bus_in;

  int n_checks = 0;
  int n_fail   = 0;

  txn_t     sb[$];
  txn_t     cur;
  bit       active = 1'b0;
  int       rel = 0;
  bit [7:0] rd_exp [2];
  bit [7:0] ref_mem [256];
  logic     rst_at_edge = 1'b0;

  // External latch/memory model.
  logic [7:0] lat = 8'h00;
  logic [7:0] mem [256];
  bit         wr_valid [256];

  xmem_bus_arbiter #(.READ_WAIT(RW), .WRITE_PULSE(WP)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
    .bus_out(bus_out), .bus_in(bus_in), .bus_oe(bus_oe),
    .le(le), .moe(moe), .mwe(mwe)
  );

  always #5 clk = ~clk;

  function automatic bit [7:0] init_val(input bit [7:0] a);
    return (a == 8'h2A) ? 8'h5C : (a ^ 8'hA5);
  endfunction

  assign bus_in = moe ? (wr_valid[lat] ? mem[lat] : init_val(lat)) : 8'h00;

  always @(negedge clk) begin
    if (le && bus_oe) lat <= bus_out;
    if (mwe && bus_oe) begin
      mem[lat]      <= bus_out;
      wr_valid[lat] <= 1'b1;
    end
  end

  always @(posedge clk) rst_at_edge <= reset;

  task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input bit p, input bit w, input bit [7:0] a, input bit [7:0] d);
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
  endtask

  task automatic push(input bit p, input bit w, input bit [7:0] a, input bit [7:0] d);
    txn_t t;
    t.port = p; t.we = w; t.addr = a; t.wdata = d; t.rexp = ref_mem[a];
    if (w) ref_mem[a] = d;
    sb.push_back(t);
  endtask

  task automatic wait_quiet();
    bit quiet;
    quiet = 1'b0;
    for (int i = 0; i < 300 && !quiet; i++) begin
      @(negedge clk);
      quiet = (sb.size() == 0) && !active && !req0 && !req1;
    end
    @(negedge clk);
    check_val("quiet_timeout", {7'd0, quiet}, 8'h01);
  endtask

  task automatic pair(input bit first, input bit [7:0] a0, input bit [7:0] a1);
    drive(1'b0, 1'b0, a0, 8'h00);
    drive(1'b1, 1'b0, a1, 8'h00);
    if (first) begin push(1'b1, 1'b0, a1, 8'h00); push(1'b0, 1'b0, a0, 8'h00); end
    else       begin push(1'b0, 1'b0, a0, 8'h00); push(1'b1, 1'b0, a1, 8'h00); end
    wait_quiet();
  endtask

  // Cycle monitor: strobe timing, done/rdata, invariants.
  initial begin
    bit e_le, e_moe, e_mwe, e_oe, e_d0, e_d1;
    int done_rel;
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin
        active = 1'b0;
        rd_exp[0] = 8'h00;
        rd_exp[1] = 8'h00;
        check_val("rst_le",     {7'd0, le},     8'h00);
        check_val("rst_moe",    {7'd0, moe},    8'h00);
        check_val("rst_mwe",    {7'd0, mwe},    8'h00);
        check_val("rst_bus_oe", {7'd0, bus_oe}, 8'h01);
        check_val("rst_bus_out", bus_out,       8'h00);
        check_val("rst_done",   {6'd0, done1, done0}, 8'h00);
        check_val("rst_rdata0", rdata0, 8'h00);
        check_val("rst_rdata1", rdata1, 8'h00);
      end else begin
        if (!active && le) begin
          if (sb.size() == 0) begin
            check_val("unexpected_grant", {7'd0, le}, 8'h00);
          end else begin
            cur = sb.pop_front();
            active = 1'b1;
            rel = 0;
          end
        end
        done_rel = cur.we ? (4 + WP) : (3 + RW);
        e_le  = active && rel == 0;
        e_moe = active && !cur.we && rel >= 3 && rel <= 2 + RW;
        e_mwe = active && cur.we && rel >= 3 && rel <= 2 + WP;
        e_oe  = !active || cur.we || !(rel >= 2 && rel <= 2 + RW);
        e_d0  = active && rel == done_rel && !cur.port;
        e_d1  = active && rel == done_rel && cur.port;
        if (active && rel == done_rel && !cur.we) rd_exp[cur.port] = cur.rexp;
        check_val("le",     {7'd0, le},     {7'd0, e_le});
        check_val("moe",    {7'd0, moe},    {7'd0, e_moe});
        check_val("mwe",    {7'd0, mwe},    {7'd0, e_mwe});
        check_val("bus_oe", {7'd0, bus_oe}, {7'd0, e_oe});
        check_val("done0",  {7'd0, done0},  {7'd0, e_d0});
        check_val("done1",  {7'd0, done1},  {7'd0, e_d1});
        check_val("rdata0", rdata0, rd_exp[0]);
        check_val("rdata1", rdata1, rd_exp[1]);
        if (active && rel <= 1) check_val("bus_addr", bus_out, cur.addr);
        if (active && cur.we && rel >= 2 && rel <= 3 + WP) check_val("bus_wdata", bus_out, cur.wdata);
        if (active && rel == done_rel) begin
          if (cur.we) check_val("mem_write", wr_valid[cur.addr] ? mem[cur.addr] : init_val(cur.addr), cur.wdata);
          if (cur.port) req1 = 1'b0;
          else          req0 = 1'b0;
          active = 1'b0;
        end
        rel++;
      end
      check_val("inv_moe_mwe", {7'd0, moe & mwe},     8'h00);
      check_val("inv_moe_oe",  {7'd0, moe & bus_oe},  8'h00);
      check_val("inv_mwe_oe",  {7'd0, mwe & ~bus_oe}, 8'h00);
    end
  end

  initial begin
    bit seen;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single read, port 0.
    drive(1'b0, 1'b0, 8'h2A, 8'h00); push(1'b0, 1'b0, 8'h2A, 8'h00);
    wait_quiet();
    check_val("read_5c", rdata0, 8'h5C);

    // Single write, port 1, then read it back.
    drive(1'b1, 1'b1, 8'h15, 8'hF3); push(1'b1, 1'b1, 8'h15, 8'hF3);
    wait_quiet();
    drive(1'b1, 1'b0, 8'h15, 8'h00); push(1'b1, 1'b0, 8'h15, 8'h00);
    wait_quiet();

    // Contended reads: four transactions 0,1,0,1.
    pair(1'b0, 8'h01, 8'h02);
    pair(1'b0, 8'h03, 8'h04);
    // Port 0 alone moves the pointer to 1, so the next tie goes to port 1.
    drive(1'b0, 1'b0, 8'h05, 8'h00); push(1'b0, 1'b0, 8'h05, 8'h00);
    wait_quiet();
    pair(1'b1, 8'h06, 8'h07);

    // Address change during HOLD is ignored.
    drive(1'b0, 1'b0, 8'h10, 8'h00); push(1'b0, 1'b0, 8'h10, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = le;
    end
    @(negedge clk);
    addr0 = 8'h90;
    wait_quiet();
    check_val("hold_addr_rdata", rdata0, 8'hB5);

    // Reset during WR_PULSE; pointer was left at port 1 by this grant.
    drive(1'b0, 1'b1, 8'h33, 8'h77); push(1'b0, 1'b1, 8'h33, 8'h77);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = mwe;
    end
    check_val("saw_wr_pulse", {7'd0, seen}, 8'h01);
    reset = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    repeat (8) @(negedge clk);
    pair(1'b0, 8'h40, 8'h41);

    // Random single transactions.
    for (int k = 0; k < 10; k++) begin
      bit       p, w;
      bit [7:0] a, d;
      p = 1'(($urandom >> 4) & 1);
      w = 1'(($urandom >> 5) & 1);
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      drive(p, w, a, d); push(p, w, a, d);
      wait_quiet();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
